irq_pending_arbiter: RTL

//  Receiving end of the core interrupt interface: samples irq_software/timer/external/fast[14:0]/nm,

---
 rtl/irq_rx_pkg.sv | 57 +++++
 rtl/irq_sync_edge.sv | 48 ++++
 rtl/irq_pending_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/irq_rx_pkg.sv
// Shared types, cause encodings and source indices for the interrupt receiver.
// The pending vector order is {nm, fast[14:0], ext, tmr, sw}.
package irq_rx_pkg;

  localparam int NumSrc  = 19;
  localparam int NumFast = 15;

  localparam int IdxSw    = 0;
  localparam int IdxTmr   = 1;
  localparam int IdxExt   = 2;
  localparam int IdxFast0 = 3;
  localparam int IdxNm    = 18;

  localparam logic [4:0] CauseSw    = 5'd3;
  localparam logic [4:0] CauseTmr   = 5'd7;
  localparam logic [4:0] CauseExt   = 5'd11;
  localparam logic [4:0] CauseFast0 = 5'd16;
  localparam logic [4:0] CauseNm    = 5'd31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

  // Lowest priority is written first so higher-priority hits overwrite it.
  function automatic logic [4:0] prio_select(input logic [NumSrc-1:0] cand);
    logic [4:0] id;
    id = 5'd0;
    if (cand[IdxTmr]) id = CauseTmr;
    if (cand[IdxSw])  id = CauseSw;
    if (cand[IdxExt]) id = CauseExt;
    for (int i = NumFast - 1; i >= 0; i--) begin
      if (cand[IdxFast0 + i]) id = CauseFast0 + 5'(i);
    end
    if (cand[IdxNm])  id = CauseNm;
    return id;
  endfunction

  function automatic logic [NumSrc-1:0] cause_mask(input logic [4:0] id);
    logic [NumSrc-1:0] m;
    m = {NumSrc{1'b0}};
    case (id)
      CauseSw:  m[IdxSw]  = 1'b1;
      CauseTmr: m[IdxTmr] = 1'b1;
      CauseExt: m[IdxExt] = 1'b1;
      CauseNm:  m[IdxNm]  = 1'b1;
      default: begin
        for (int i = 0; i < NumFast; i++) begin
          if (id == CauseFast0 + 5'(i)) m[IdxFast0 + i] = 1'b1;
        end
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source input synchronizer with a rising-edge detector on the synchronized value.
// Stages=0 passes the input straight through for sources already in the clk_i domain.
module irq_sync_edge #(
  parameter int Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_d,
  output logic o_level,
  output logic o_edge
);

  logic w_level;
  logic r_prev;

  if (Stages == 0) begin : g_bypass
    assign w_level = i_d;
  end else begin : g_sync
    logic [Stages-1:0] r_sync;

    // Synchronizer shift chain.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_sync <= {Stages{1'b0}};
      end else begin
        r_sync[0] <= i_d;
        for (int k = 1; k < Stages; k++) begin
          r_sync[k] <= r_sync[k-1];
        end
      end
    end

    assign w_level = r_sync[Stages-1];
  end

  // Previous synchronized level for edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_edge  = w_level & ~r_prev;

endmodule

// File: rtl/irq_pending_arbiter.sv
// Interrupt receiver: synchronizes sources, latches edge events, masks, and offers the
// highest-priority cause to the core over a req/ack handshake with a post-ack holdoff.
module irq_pending_arbiter
  import irq_rx_pkg::*;
#(
  parameter int                SyncStages    = 2,
  parameter logic [NumSrc-1:0] EdgeMask      = 19'h0,
  parameter int                HoldoffCycles = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  input  logic [14:0] irq_fast_i,
  input  logic        irq_nm_i,
  input  logic [17:0] irq_en_i,
  output logic        irq_req_o,
  output logic [4:0]  irq_id_o,
  input  logic        irq_ack_i,
  output logic [18:0] pending_o,
  output logic        ack_err_o
);

  localparam int CntW = (HoldoffCycles > 1) ? $clog2(HoldoffCycles + 1) : 1;

  logic [NumSrc-1:0] w_src;
  logic [NumSrc-1:0] w_level;
  logic [NumSrc-1:0] w_edge;
  logic [NumSrc-1:0] w_pending;
  logic [NumSrc-1:0] w_cand;
  logic              w_any;
  logic [4:0]        w_win_id;

  irq_state_e        r_state;
  logic              r_req;
  logic [4:0]        r_id;
  logic [CntW-1:0]   r_cnt;
  logic              r_ack_err;
  logic [NumSrc-1:0] r_pend_edge;

  irq_state_e        w_state_nxt;
  logic              w_req_nxt;
  logic [4:0]        w_id_nxt;
  logic [CntW-1:0]   w_cnt_nxt;
  logic              w_ack_err_nxt;
  logic [NumSrc-1:0] w_clr;
  logic [NumSrc-1:0] w_pend_edge_nxt;

  assign w_src = {irq_nm_i, irq_fast_i, irq_external_i, irq_timer_i, irq_software_i};

  for (genvar g = 0; g < NumSrc; g++) begin : g_src
    irq_sync_edge #(
      .Stages (SyncStages)
    ) u_sync (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_d     (w_src[g]),
      .o_level (w_level[g]),
      .o_edge  (w_edge[g])
    );
  end

  // Level sources mirror the synchronized input; edge sources use the latched flag.
  assign w_pending = (r_pend_edge & EdgeMask) | (w_level & ~EdgeMask);
  assign w_cand    = w_pending & {1'b1, irq_en_i};
  assign w_any     = |w_cand;
  assign w_win_id  = prio_select(w_cand);

  // Next-state and next-output logic for the handshake FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_id_nxt      = r_id;
    w_cnt_nxt     = r_cnt;
    w_ack_err_nxt = 1'b0;
    w_clr         = {NumSrc{1'b0}};
    case (r_state)
      IDLE: begin
        w_ack_err_nxt = irq_ack_i;
        if (w_any) begin
          w_state_nxt = REQ;
          w_req_nxt   = 1'b1;
          w_id_nxt    = w_win_id;
        end else begin
          w_req_nxt   = 1'b0;
        end
      end
      REQ: begin
        w_req_nxt = 1'b1;
        if (irq_ack_i) begin
          w_clr     = cause_mask(r_id) & EdgeMask;
          w_req_nxt = 1'b0;
          if (HoldoffCycles == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = HOLDOFF;
            w_cnt_nxt   = CntW'(HoldoffCycles);
          end
        end else begin
          w_state_nxt = REQ;
        end
      end
      HOLDOFF: begin
        w_req_nxt     = 1'b0;
        w_ack_err_nxt = irq_ack_i;
        if (r_cnt <= CntW'(1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {CntW{1'b0}};
        end else begin
          w_cnt_nxt   = r_cnt - CntW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
        w_cnt_nxt   = {CntW{1'b0}};
      end
    endcase
    // A new edge in the same cycle as the clearing ack keeps the bit pending.
    w_pend_edge_nxt = (r_pend_edge & ~w_clr) | (w_edge & EdgeMask);
  end

  // State, output and pending registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_id        <= 5'd0;
      r_cnt       <= {CntW{1'b0}};
      r_ack_err   <= 1'b0;
      r_pend_edge <= {NumSrc{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_id        <= w_id_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ack_err   <= w_ack_err_nxt;
      r_pend_edge <= w_pend_edge_nxt;
    end
  end

  assign irq_req_o = r_req;
  assign irq_id_o  = r_id;
  assign ack_err_o = r_ack_err;
  assign pending_o = w_pending;

endmodule
